// File: rtl/seg7_scan.sv
// Multi-digit 7-segment scan driver with double-buffered display contents.
// Optional leading-zero blanking is built when LEAD_ZERO_BLANK_EN is defined.
module seg7_scan #(
  parameter int DIGITS       = 4,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  scan_tick_in,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [DIGITS-1:0]     an_out,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic                  frame_done
);

  localparam int                IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]     LAST    = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF  = COMMON_ANODE ? '1 : '0;
  localparam logic [6:0]        SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = COMMON_ANODE;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic                  s1_q, s2_q, s3_q;
  logic                  tick;
  logic                  wrap;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;
  logic [DIGITS-1:0]     blank_mask;
  logic [DIGITS-1:0]     an_raw;
  logic [6:0]            seg_raw;
  logic                  dp_raw;
  logic [3:0]            nib;

  assign tick = s2_q & ~s3_q;
  assign wrap = tick && (state_q == ST_SCAN) && (idx_q == LAST);

  // Index, frame and buffer next-state; a load coinciding with a wrap bypasses
  // the pending buffer so the new value is visible from digit 0 of that frame.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    fd_d         = 1'b0;

    if (tick) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_SCAN;
        idx_d   = '0;
      end else if (wrap) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    if (wrap) begin
      fd_d = 1'b1;
    end

    if (load && wrap) begin
      disp_val_d   = value_in;
      disp_dp_d    = dp_in;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end else if (wrap && pend_valid_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic lead;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    blank_mask = '0;
    lead       = 1'b1;
    for (int unsigned j = 0; j < DIGITS - 1; j++) begin
      if (lead && (disp_val_d[(DIGITS-1-j)*4 +: 4] == 4'h0)) begin
        blank_mask[DIGITS-1-j] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  always_comb begin
    blank_mask = '0;
  end
`endif

  always_comb begin
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    an_raw  = '0;
    seg_raw = '0;
    dp_raw  = 1'b0;
    nib     = disp_val_d[{idx_d, 2'b00} +: 4];

    if (tick) begin
      an_raw[idx_d] = 1'b1;
      seg_raw       = blank_mask[idx_d] ? 7'h00 : hex7(nib);
      dp_raw        = disp_dp_d[idx_d];
      an_d          = COMMON_ANODE ? ~an_raw  : an_raw;
      seg_d         = COMMON_ANODE ? ~seg_raw : seg_raw;
      dp_d          = COMMON_ANODE ? ~dp_raw  : dp_raw;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      fd_q         <= 1'b0;
    end else begin
      s1_q         <= scan_tick_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fd_q         <= fd_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan (DIGITS=4, common anode): vector table, corner sequences,
// and randomized ticks/loads against a tick-count based display model.
module tb_seg7_scan;

  localparam int D = 4;
  localparam logic [6:0] SEGTAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] ZS = 7'h7F;
`else
  localparam logic [6:0] ZS = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan #(.DIGITS(D), .COMMON_ANODE(1'b1)) dut (
    .clock_in    (clk),
    .reset_n     (reset_n),
    .scan_tick_in(tick_in),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load        (load),
    .an_out      (an_out),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: the scan position is derived from the number of ticks.
  int          ntick;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pv, m_wrap;

  task automatic model_reset();
    ntick = 0; m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pv = 0; m_wrap = 0;
  endtask

  task automatic model_load(input logic [15:0] v, input logic [3:0] d);
    m_pend = v; m_pdp = d; m_pv = 1;
  endtask

  task automatic model_tick(input bit ld, input logic [15:0] v, input logic [3:0] d);
    ntick++;
    m_wrap = (ntick > 1) && (((ntick - 1) % D) == 0);
    if (m_wrap && ld) begin
      m_disp = v; m_ddp = d; m_pv = 0;
    end else if (ld) begin
      model_load(v, d);
    end else if (m_wrap && m_pv) begin
      m_disp = m_pend; m_ddp = m_pdp; m_pv = 0;
    end
  endtask

  function automatic logic [6:0] exp_seg(input int dg);
    logic [3:0] nib;
    nib = 4'((m_disp >> (4 * dg)) & 16'hF);
`ifdef LEAD_ZERO_BLANK_EN
    begin
      int top;
      top = -1;
      for (int k = 0; k < D; k++)
        if (((m_disp >> (4 * k)) & 16'hF) != 0) top = k;
      if (dg > 0 && dg > top) return 7'h7F;
    end
`endif
    return ~SEGTAB[nib];
  endfunction

  task automatic check_model(input string tag);
    int         dg;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    dg    = (ntick - 1) % D;
    e_an  = ~(4'b0001 << dg);
    e_seg = exp_seg(dg);
    e_dp  = ~m_ddp[dg];
    chk({tag, "_an"},  an_out,     e_an);
    chk({tag, "_seg"}, seg_out,    e_seg);
    chk({tag, "_dp"},  dp_out,     e_dp);
    chk({tag, "_fd"},  frame_done, m_wrap);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    load = 1'b1; value_in = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
    model_load(v, d);
  endtask

  // Rising edge at a negedge; outputs settle after the 3rd posedge.
  task automatic tick_cycle(input bit ld, input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    tick_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (ld) begin
      load = 1'b1; value_in = v; dp_in = d;
    end
    @(negedge clk);
    load = 1'b0;
    model_tick(ld, v, d);
  endtask

  typedef struct {
    bit          ld;
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  prev_an;
    logic [6:0]  prev_seg;
    logic [15:0] rv;
    logic [3:0]  rd;
    bit          rl;

    tbl[0]  = '{0, 16'h0000, 4'h0, 4'hE, 7'h40, 1'b1, 1'b0};
    tbl[1]  = '{0, 16'h0000, 4'h0, 4'hD, ZS,    1'b1, 1'b0};
    tbl[2]  = '{0, 16'h0000, 4'h0, 4'hB, ZS,    1'b1, 1'b0};
    tbl[3]  = '{0, 16'h0000, 4'h0, 4'h7, ZS,    1'b1, 1'b0};
    tbl[4]  = '{0, 16'h0000, 4'h0, 4'hE, 7'h0E, 1'b0, 1'b1};
    tbl[5]  = '{0, 16'h0000, 4'h0, 4'hD, 7'h08, 1'b1, 1'b0};
    tbl[6]  = '{0, 16'h0000, 4'h0, 4'hB, 7'h24, 1'b0, 1'b0};
    tbl[7]  = '{0, 16'h0000, 4'h0, 4'h7, 7'h79, 1'b1, 1'b0};
    tbl[8]  = '{1, 16'h3456, 4'h8, 4'hE, 7'h02, 1'b1, 1'b1};
    tbl[9]  = '{0, 16'h0000, 4'h0, 4'hD, 7'h12, 1'b1, 1'b0};
    tbl[10] = '{0, 16'h0000, 4'h0, 4'hB, 7'h19, 1'b1, 1'b0};
    tbl[11] = '{0, 16'h0000, 4'h0, 4'h7, 7'h30, 1'b0, 1'b0};

    model_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an",  an_out,     4'hF);
    chk("rst_seg", seg_out,    7'h7F);
    chk("rst_dp",  dp_out,     1'b1);
    chk("rst_fd",  frame_done, 1'b0);
    reset_n = 1'b1;

    // Display stays at 0 until the first wrap commits the load.
    do_load(16'h12AF, 4'b0101);
    for (int i = 0; i < 12; i++) begin
      tick_cycle(tbl[i].ld, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d_an", i),  an_out,     tbl[i].an);
      chk($sformatf("vec%0d_seg", i), seg_out,    tbl[i].seg);
      chk($sformatf("vec%0d_dp", i),  dp_out,     tbl[i].dp);
      chk($sformatf("vec%0d_fd", i),  frame_done, tbl[i].fd);
      if (tbl[i].fd) begin
        @(negedge clk);
        chk($sformatf("vec%0d_fd_once", i), frame_done, 1'b0);
      end
    end

    // Latency: outputs move only on the 3rd posedge after the rise.
    @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    prev_an = an_out;
    tick_in = 1'b1;
    @(negedge clk);
    chk("lat_1", an_out, prev_an);
    @(negedge clk);
    chk("lat_2", an_out, prev_an);
    @(negedge clk);
    model_tick(0, '0, '0);
    check_model("lat_3");

    // Falling edge is ignored.
    tick_in  = 1'b0;
    prev_an  = an_out;
    prev_seg = seg_out;
    repeat (4) @(negedge clk);
    chk("fall_an",  an_out,     prev_an);
    chk("fall_seg", seg_out,    prev_seg);
    chk("fall_fd",  frame_done, 1'b0);

    // Last load before the wrap wins.
    do_load(16'h1111, 4'h0);
    tick_cycle(0, '0, '0);
    check_model("ovw_a");
    do_load(16'h2222, 4'h0);
    tick_cycle(0, '0, '0);
    check_model("ovw_b");
    tick_cycle(0, '0, '0);
    check_model("ovw_c");
    tick_cycle(0, '0, '0);
    check_model("ovw_wrap");
    chk("last_load_wins", seg_out, 7'h24);
    for (int i = 0; i < 3; i++) begin
      tick_cycle(0, '0, '0);
      chk($sformatf("no1111_%0d", i), seg_out, 7'h24);
    end

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
        rd = 4'($urandom);
        do_load(rv, rd);
      end
      rl = ($urandom_range(0, 4) == 0);
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      rd = 4'($urandom);
      tick_cycle(rl, rv, rd);
      check_model($sformatf("rnd%0d", i));
    end

    if (((ntick - 1) % D) == 0) begin
      tick_cycle(0, '0, '0);
      check_model("pre_rst");
    end
    @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_an",  an_out,     4'hF);
    chk("midrst_seg", seg_out,    7'h7F);
    chk("midrst_dp",  dp_out,     1'b1);
    chk("midrst_fd",  frame_done, 1'b0);
    reset_n = 1'b1;
    model_reset();
    tick_cycle(0, '0, '0);
    check_model("post_rst");
    chk("post_rst_seg0", seg_out, 7'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
